hw_irq_pending_ctrl: RTL and testbench
======================================

# hw_irq_pending_ctrl

Captures raw interrupt request lines into a sticky pending register, applies a per-line enable mask, selects the highest-index eligible request and presents its index to a downstream consumer over a valid/ready handshake. It then tracks the accepted request as in-service until an end-of-interrupt pulse. It sits between the raw request sources and the interrupt-index consumer stage of the interrupt path.

## Interface
- `n`, default 3: index width; the block handles 2**n request lines.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `irq_in`, input, 2**n: raw request lines, bit i = source i.
- `irq_mask`, input, 2**n: per-line enable; 1 = eligible for selection.
- `irq_valid`, output, 1: offer of `irq_id` to the consumer.
- `irq_id`, output, n: index of the offered or in-service request.
- `irq_ready`, input, 1: consumer accepts the offer; transfer when `irq_valid && irq_ready`.
- `irq_eoi`, input, 1: end-of-interrupt pulse for the in-service request.
- `isr_active`, output, 1: a request is in service.
- `irq_pending`, output, 2**n: current pending register, unmasked.

## Operation
- Edge capture: `prev_in` register; `pending[i]` is set when `irq_in[i] & ~prev_in[i]`. A bit stays set until its index is accepted.
- Selection: `elig = pending & irq_mask`. The highest set index wins.
- FSM, `irq_state_e`:
  - IDLE: if `elig != 0`, latch the winner into `irq_id` and go to OFFER. Otherwise stay in IDLE.
  - OFFER: `irq_valid = 1`. `irq_id` is frozen: no re-arbitration when a higher request arrives or the mask changes, and the offer is held even if its mask bit drops. On transfer, clear `pending[irq_id]` and go to ACTIVE.
  - ACTIVE: `isr_active = 1`, `irq_valid = 0`, `irq_id` holds the in-service index. When `irq_eoi = 1`, go to IDLE.
- `irq_eoi` outside ACTIVE and `irq_ready` outside OFFER are ignored.
- Simultaneous clear and new edge on the same bit: the set wins, so the bit stays pending.
- Masked pending bits are retained and become eligible when unmasked.
- Reset values: `pending = 0`, `prev_in = 0`, state IDLE, `irq_valid = 0`, `irq_id = 0`, `isr_active = 0`, `irq_pending = 0`.
- A line that is high at reset release is captured as an edge on the first cycle.
- Reset asserted mid-offer or mid-service aborts the offer or service. All state returns to reset values at that edge, with no transfer.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `irq_in` rises before edge k: pending is set at edge k, and `irq_valid` is high after edge k+1, provided the FSM is IDLE and the line is unmasked.
- Transfer at edge t: `irq_valid` is low and `isr_active` is high after t, and the pending bit is cleared at t.
- `irq_eoi` sampled at edge e: IDLE after e. The next offer is valid after e+1 at the earliest.
- Maximum throughput: one request per 3 cycles (OFFER, ACTIVE, IDLE).

## Configuration
- `HW_IRQ_LEVEL_EN` defined: level-sensitive capture.
  - `pending <= irq_in` every cycle; no edge detect, and `prev_in` is removed.
  - Accept does not clear pending; the source must drop its line before EOI to avoid immediate re-service.
- `HW_IRQ_LEVEL_EN` undefined: edge-triggered sticky capture as described in Operation.

## Structure
- Package `hw_irq_pkg`: `irq_state_e` enum (IRQ_IDLE, IRQ_OFFER, IRQ_ACTIVE) and localparam default `IRQ_IDX_W = 3`.
- Sub-module `hw_irq_sel #(n)`: combinational block taking `elig[2**n-1:0]` and producing `sel_idx[n-1:0]` (highest set bit) and `sel_any`. It is instantiated once.
- Top level holds the registers, the FSM and the capture logic.

## Test plan
- n=3, mask=8'hFF, pulse `irq_in[5]` one cycle, `irq_ready=1`: `irq_valid` high 2 cycles after the rise with id=5. Accepted the same cycle; `isr_active=1`; `irq_pending=8'h00`.
- Rise bits 2 and 6 in the same cycle: id=6 is offered first. After EOI, id=2 is offered; pending goes 8'h44, then 8'h04, then 8'h00.
- During OFFER of id=3 with `irq_ready=0`, raise bit 7 and clear mask bit 3: `irq_id` stays 3 and valid stays high until ready. Bit 7 is offered after the next EOI.
- mask=8'h00 with bit 4 pulsed: no valid, `irq_pending=8'h10`. Setting mask=8'h10 gives an offer of id=4 one cycle later.
- Pulse bit 1 again in the same cycle its offer is accepted: `pending[1]` stays 1 and id=1 is re-offered after EOI.
- Assert `rst_n=0` during ACTIVE: the next cycle shows all outputs 0 and state IDLE. With `HW_IRQ_LEVEL_EN`, a held line re-offers after reset release.

Source files
------------

// File: rtl/hw_irq_pkg.sv
// Shared types and defaults for the interrupt pending controller.
package hw_irq_pkg;

    localparam int IRQ_IDX_W = 3;

    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_OFFER  = 2'd1,
        IRQ_ACTIVE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/hw_irq_sel.sv
// Highest-index priority selector over the eligible request vector.
module hw_irq_sel
    import hw_irq_pkg::*;
#(
    parameter int n = IRQ_IDX_W
) (
    input  logic [2**n-1:0] elig,
    output logic [n-1:0]    sel_idx,
    output logic            sel_any
);

    // Later (higher) indices override earlier ones, so the top set bit wins.
    always_comb begin
        sel_idx = {n{1'b0}};
        sel_any = |elig;
        for (int i = 0; i < 2**n; i++) begin
            sel_idx = elig[i] ? n'(i) : sel_idx;
        end
    end

endmodule

// File: rtl/hw_irq_pending_ctrl.sv
// Interrupt pending register, priority select, valid/ready offer and in-service tracking.
// Define HW_IRQ_LEVEL_EN for level-sensitive capture instead of edge-triggered sticky pending.
module hw_irq_pending_ctrl
    import hw_irq_pkg::*;
#(
    parameter int n = IRQ_IDX_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2**n-1:0] irq_in,
    input  logic [2**n-1:0] irq_mask,
    output logic            irq_valid,
    output logic [n-1:0]    irq_id,
    input  logic            irq_ready,
    input  logic            irq_eoi,
    output logic            isr_active,
    output logic [2**n-1:0] irq_pending
);

    localparam int NL = 2**n;

    irq_state_e      state_q, state_d;
    logic [NL-1:0]   pending_q, pending_d;
    logic [n-1:0]    id_q, id_d;
    logic            valid_q, valid_d;
    logic            active_q, active_d;

    logic [NL-1:0]   elig_s;
    logic [n-1:0]    sel_idx_s;
    logic            sel_any_s;
    logic            xfer_s;

    assign elig_s = pending_q & irq_mask;
    assign xfer_s = valid_q & irq_ready;

    hw_irq_sel #(.n(n)) u_sel (
        .elig    (elig_s),
        .sel_idx (sel_idx_s),
        .sel_any (sel_any_s)
    );

`ifdef HW_IRQ_LEVEL_EN
    // Pending simply mirrors the request lines; acceptance does not clear it.
    always_comb begin
        pending_d = irq_in;
    end
`else
    logic [NL-1:0]   prev_in_q;
    logic [NL-1:0]   set_s;
    logic [NL-1:0]   clr_s;

    assign set_s = irq_in & ~prev_in_q;

    // Clear the accepted bit; a new edge on the same bit takes precedence.
    always_comb begin
        clr_s = {NL{1'b0}};
        if (xfer_s) begin
            clr_s[id_q] = 1'b1;
        end else begin
            clr_s = {NL{1'b0}};
        end
        pending_d = (pending_q & ~clr_s) | set_s;
    end

    // Previous-sample register for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_in_q <= {NL{1'b0}};
        end else begin
            prev_in_q <= irq_in;
        end
    end
`endif

    // Offer/service FSM; outputs are next-state decoded and then registered.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        valid_d  = 1'b0;
        active_d = 1'b0;
        case (state_q)
            IRQ_IDLE: begin
                if (sel_any_s) begin
                    id_d    = sel_idx_s;
                    state_d = IRQ_OFFER;
                    valid_d = 1'b1;
                end else begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_OFFER: begin
                if (xfer_s) begin
                    state_d  = IRQ_ACTIVE;
                    active_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            IRQ_ACTIVE: begin
                if (irq_eoi) begin
                    state_d = IRQ_IDLE;
                end else begin
                    active_d = 1'b1;
                end
            end
            default: begin
                state_d = IRQ_IDLE;
            end
        endcase
    end

    // State, pending and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IRQ_IDLE;
            pending_q <= {NL{1'b0}};
            id_q      <= {n{1'b0}};
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    assign irq_valid   = valid_q;
    assign irq_id      = id_q;
    assign isr_active  = active_q;
    assign irq_pending = pending_q;

endmodule

// File: tb/tb_hw_irq_pending_ctrl.sv
// Randomised + directed bench for hw_irq_pending_ctrl with a reference model and offer scoreboard.
module tb_hw_irq_pending_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] irq_mask;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_ready;
    logic       irq_eoi;
    logic       isr_active;
    logic [7:0] irq_pending;

    int errors = 0;
    int checks = 0;

    // reference model: phase 0 = waiting, 1 = offering, 2 = in service
    int         m_phase = 0;
    logic [7:0] m_pend  = 8'h00;
    logic [7:0] m_prev  = 8'h00;
    logic [2:0] m_id    = 3'd0;
    logic [2:0] exp_q[$];

    hw_irq_pending_ctrl #(.n(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .irq_mask    (irq_mask),
        .irq_valid   (irq_valid),
        .irq_id      (irq_id),
        .irq_ready   (irq_ready),
        .irq_eoi     (irq_eoi),
        .isr_active  (isr_active),
        .irq_pending (irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_step();
        logic [7:0] elig;
        logic [7:0] rise;
        bit         take;
        if (!rst_n) begin
            m_phase = 0;
            m_pend  = 8'h00;
            m_prev  = 8'h00;
            m_id    = 3'd0;
        end else begin
            elig = m_pend & irq_mask;
            rise = irq_in & ~m_prev;
            take = (m_phase == 1) && irq_ready;
            if (m_phase == 0 && elig != 8'h00) begin
                m_id    = highest(elig);
                m_phase = 1;
                exp_q.push_back(m_id);
            end else if (m_phase == 1 && irq_ready) begin
                m_phase = 2;
            end else if (m_phase == 2 && irq_eoi) begin
                m_phase = 0;
            end
`ifdef HW_IRQ_LEVEL_EN
            m_pend = irq_in;
`else
            if (take) m_pend[m_id] = 1'b0;
            m_pend = m_pend | rise;
`endif
            m_prev = irq_in;
        end
    endtask

    // Check registered outputs against the model, then apply the next inputs.
    task automatic cyc(input logic [7:0] in_v, input logic [7:0] mk, input logic rdy,
                       input logic eoi, input logic rs);
        @(negedge clk);
        chk("valid", {31'd0, irq_valid}, {31'd0, m_phase == 1});
        chk("active", {31'd0, isr_active}, {31'd0, m_phase == 2});
        chk("pending", {24'd0, irq_pending}, {24'd0, m_pend});
        chk("id", {29'd0, irq_id}, {29'd0, m_id});
        irq_in    = in_v;
        irq_mask  = mk;
        irq_ready = rdy;
        irq_eoi   = eoi;
        rst_n     = rs;
        model_step();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every new offer must match the next predicted index.
    initial begin
        logic       pv;
        logic [2:0] e;
        pv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (irq_valid && !pv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL offer_unexpected got id=%0d expected=no offer", irq_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("offer_id", {29'd0, irq_id}, {29'd0, e});
                end
            end
            pv = irq_valid;
        end
    end

    initial begin
        irq_in = 8'h00; irq_mask = 8'hFF; irq_ready = 1'b0; irq_eoi = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("rst_valid", {31'd0, irq_valid}, 32'd0);
        chk("rst_active", {31'd0, isr_active}, 32'd0);
        chk("rst_pending", {24'd0, irq_pending}, 32'h00);
        chk("rst_id", {29'd0, irq_id}, 32'd0);

`ifndef HW_IRQ_LEVEL_EN
        // single pulse on line 5
        cyc(8'h20, 8'hFF, 1'b1, 1'b0, 1'b1); after_edge(); chk("t1_pend", {24'd0, irq_pending}, 32'h20);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1); after_edge(); chk("t1_valid", {31'd0, irq_valid}, 32'd1);
        chk("t1_id", {29'd0, irq_id}, 32'd5);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1); after_edge(); chk("t1_active", {31'd0, isr_active}, 32'd1);
        chk("t1_pend0", {24'd0, irq_pending}, 32'h00);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        // lines 2 and 6 together
        cyc(8'h44, 8'hFF, 1'b0, 1'b0, 1'b1); after_edge(); chk("t2_pend44", {24'd0, irq_pending}, 32'h44);
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1); after_edge(); chk("t2_id6", {29'd0, irq_id}, 32'd6);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1); after_edge(); chk("t2_pend04", {24'd0, irq_pending}, 32'h04);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1); after_edge(); chk("t2_id2", {29'd0, irq_id}, 32'd2);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1); after_edge(); chk("t2_pend00", {24'd0, irq_pending}, 32'h00);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        // frozen offer while a higher line rises and the mask bit drops
        cyc(8'h08, 8'hFF, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        cyc(8'h80, 8'hF7, 1'b0, 1'b0, 1'b1); after_edge(); chk("t3_id_frozen", {29'd0, irq_id}, 32'd3);
        cyc(8'h00, 8'hF7, 1'b0, 1'b0, 1'b1); after_edge(); chk("t3_valid_held", {31'd0, irq_valid}, 32'd1);
        cyc(8'h00, 8'hF7, 1'b1, 1'b0, 1'b1); after_edge(); chk("t3_pend80", {24'd0, irq_pending}, 32'h80);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1); after_edge(); chk("t3_id7", {29'd0, irq_id}, 32'd7);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        // masked line retained, offered once unmasked
        cyc(8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b1); after_edge(); chk("t4_no_valid", {31'd0, irq_valid}, 32'd0);
        chk("t4_pend10", {24'd0, irq_pending}, 32'h10);
        cyc(8'h00, 8'h10, 1'b0, 1'b0, 1'b1); after_edge(); chk("t4_id4", {29'd0, irq_id}, 32'd4);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        // re-pulse on the cycle of acceptance: set wins over clear
        cyc(8'h02, 8'hFF, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        cyc(8'h02, 8'hFF, 1'b1, 1'b0, 1'b1); after_edge(); chk("t5_pend02", {24'd0, irq_pending}, 32'h02);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1); after_edge(); chk("t5_reoffer", {29'd0, irq_id}, 32'd1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1); after_edge(); chk("t5_active", {31'd0, isr_active}, 32'd1);
        // reset during service
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0); after_edge(); chk("t6_active0", {31'd0, isr_active}, 32'd0);
        chk("t6_id0", {29'd0, irq_id}, 32'd0);
        cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
`else
        // held level line is re-offered after a reset during service
        cyc(8'h08, 8'hFF, 1'b0, 1'b0, 1'b1); after_edge(); chk("lv_pend08", {24'd0, irq_pending}, 32'h08);
        cyc(8'h08, 8'hFF, 1'b0, 1'b0, 1'b1); after_edge(); chk("lv_id3", {29'd0, irq_id}, 32'd3);
        cyc(8'h08, 8'hFF, 1'b1, 1'b0, 1'b1); after_edge(); chk("lv_active", {31'd0, isr_active}, 32'd1);
        cyc(8'h08, 8'hFF, 1'b0, 1'b0, 1'b0); after_edge(); chk("lv_rst_pend", {24'd0, irq_pending}, 32'h00);
        chk("lv_rst_active", {31'd0, isr_active}, 32'd0);
        cyc(8'h08, 8'hFF, 1'b0, 1'b0, 1'b1);
        cyc(8'h08, 8'hFF, 1'b0, 1'b0, 1'b1); after_edge(); chk("lv_reoffer", {31'd0, irq_valid}, 32'd1);
        cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
        cyc(8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
`endif

        for (int k = 0; k < 800; k++) begin
            cyc(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 99) != 0));
        end
        repeat (3) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
